exec_issue: RTL
===============

EXEC_ISSUE -- requirements
Module: exec_issue

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 128, queue entry width; TAG_WIDTH, default 6, destination tag width; LATENCY, default 3, functional-unit cycles from fu_start to fu_result valid (>=1).
REQ-002 i_clk  input  1  single clock, all state on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  synchronous pipeline flush.
REQ-005 fifo_data  input  DATA_WIDTH  exec queue head entry, valid in the cycle fifo_rd_en=1.
REQ-006 fifo_empty  input  1  exec queue empty.
REQ-007 fifo_rd_en  output  1  pop request to exec queue (combinational).
REQ-008 fu_start  output  1  one-cycle start pulse to functional unit.
REQ-009 fu_entry  output  DATA_WIDTH  latched entry driven to functional unit.
REQ-010 fu_result  input  32  functional-unit result, sampled when latency counter reaches 0.
REQ-011 cdb_req  output  1  common data bus request.
REQ-012 cdb_grant  input  1  common data bus grant.
REQ-013 cdb_tag  output  TAG_WIDTH  tag of result on CDB.
REQ-014 cdb_data  output  32  result on CDB.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 State machine SHALL have states IDLE, EXEC, WB.
REQ-017 IDLE: fifo_rd_en = !fifo_empty & !flush; on that edge capture fifo_data into entry register, load counter with LATENCY-1, assert fu_start for the next cycle only, go to EXEC.
REQ-018 EXEC: counter decrements each cycle; at counter==0 capture fu_result and entry tag field, go to WB; fifo_rd_en SHALL be 0.
REQ-019 WB: cdb_req=1 with stable cdb_tag/cdb_data until cdb_grant=1; on grant go to IDLE.
REQ-020 Issue latency: pop edge to first cdb_req cycle SHALL be LATENCY+1 cycles with immediate grant absent.
REQ-021 cdb_tag SHALL be entry bits [EXEC_TAG_LSB+TAG_WIDTH-1:EXEC_TAG_LSB].
REQ-022 fifo_rd_en SHALL never assert when fifo_empty=1, when flush=1, or outside IDLE (except REQ-028).
REQ-023 flush in any state: next state IDLE, entry/result discarded, cdb_req and fu_start 0 next cycle; flush wins over simultaneous cdb_grant (result dropped) and over a pending pop.
REQ-024 cdb_grant outside WB SHALL be ignored.
REQ-025 Counter width $clog2(LATENCY+1); LATENCY=1 goes EXEC->WB after one EXEC cycle, no wrap.

Reset
REQ-026 On i_rst_n=0 immediately: state IDLE, counter 0, fifo_rd_en 0, fu_start 0, fu_entry 0, cdb_req 0, cdb_tag 0, cdb_data 0, busy 0; reset mid-EXEC/WB discards the entry.

Configuration
REQ-027 Macro EXEC_ISSUE_B2B_EN SHALL select back-to-back issue.
REQ-028 With EXEC_ISSUE_B2B_EN: in WB, cdb_grant=1 & !fifo_empty & !flush SHALL assert fifo_rd_en and go directly to EXEC with new entry (no IDLE bubble).
REQ-029 Without it: WB always returns to IDLE, one bubble cycle before next pop.

Structure
REQ-030 Package exec_pkg SHALL hold state enum, EXEC_TAG_LSB (0), default TAG_WIDTH and result width constant 32.
REQ-031 One sub-module exec_lat_cnt (loadable down-counter with zero flag) is natural; FSM stays in exec_issue.

Verification
REQ-032 Queue one entry tag 0x15, fu_result 0xDEADBEEF, grant on first request -> fifo_rd_en one cycle, fu_start next cycle, cdb_req 4 cycles after pop, cdb_tag 0x15, cdb_data 0xDEADBEEF.
REQ-033 Grant withheld 5 cycles in WB -> cdb_req, tag, data held stable all 5 cycles; no pop meanwhile.
REQ-034 flush in EXEC cycle 2 -> IDLE next cycle, no cdb_req for that entry, next entry pops normally.
REQ-035 flush and cdb_grant same cycle in WB -> result dropped, cdb_req 0 next cycle, fifo_rd_en 0 in flush cycle.
REQ-036 Two queued entries, grant immediate: with EXEC_ISSUE_B2B_EN second pop in grant cycle; without, one IDLE cycle between.
REQ-037 Assert i_rst_n=0 during WB -> all outputs 0 asynchronously, busy 0, fifo_empty=1 afterwards yields no pop.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared state encoding and widths for the execute-issue stage
package exec_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, WB} exec_state_e;
    localparam int EXEC_TAG_LSB   = 0;
    localparam int EXEC_TAG_WIDTH = 6;
    localparam int EXEC_RES_WIDTH = 32;
endpackage

// File: rtl/exec_lat_cnt.sv
// exec_lat_cnt: loadable down-counter with zero flag, stops at zero
module exec_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    // clear beats load beats decrement; no wrap below zero
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/exec_issue.sv
// exec_issue: pops the exec queue, times the functional unit, arbitrates the CDB (EXEC_ISSUE_B2B_EN: back-to-back issue from WB)
module exec_issue
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = EXEC_TAG_WIDTH,
    parameter int LATENCY    = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     fifo_data,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    output logic                      fu_start,
    output logic [DATA_WIDTH-1:0]     fu_entry,
    input  logic [EXEC_RES_WIDTH-1:0] fu_result,
    output logic                      cdb_req,
    input  logic                      cdb_grant,
    output logic [TAG_WIDTH-1:0]      cdb_tag,
    output logic [EXEC_RES_WIDTH-1:0] cdb_data,
    output logic                      busy
);
    localparam int CW = $clog2(LATENCY + 1);
`ifdef EXEC_ISSUE_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    exec_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0]     entry_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic [EXEC_RES_WIDTH-1:0] data_q;
    logic                      start_q;
    logic                      pop, done, cnt_zero;

    exec_lat_cnt #(.W(CW)) u_cnt (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .clr_i  (flush),
        .load_i (pop),
        .val_i  (CW'(LATENCY - 1)),
        .dec_i  (state_q == EXEC),
        .zero_o (cnt_zero)
    );

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state_q <= IDLE;
        else state_q <= state_d;

    // next state: flush dominates, a pop always enters EXEC
    always_comb
        state_d = flush                          ? IDLE :
                  pop                            ? EXEC :
                  done                           ? WB   :
                  (state_q == WB && cdb_grant)   ? IDLE : state_q;

    // outputs and handshake decodes
    always_comb begin
        pop        = !flush && !fifo_empty &&
                     (state_q == IDLE || (B2B && state_q == WB && cdb_grant));
        done       = state_q == EXEC && cnt_zero;
        fifo_rd_en = pop;
        busy       = state_q != IDLE;
        cdb_req    = state_q == WB;
    end

    // entry latch, start pulse and result capture; flush discards everything
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            entry_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= pop;
            if (flush) begin
                entry_q <= '0;
                tag_q   <= '0;
                data_q  <= '0;
            end else begin
                if (pop) entry_q <= fifo_data;
                if (done) begin
                    tag_q  <= entry_q[EXEC_TAG_LSB +: TAG_WIDTH];
                    data_q <= fu_result;
                end
            end
        end

    assign fu_start = start_q;
    assign fu_entry = entry_q;
    assign cdb_tag  = tag_q;
    assign cdb_data = data_q;
endmodule
